sram_boot_arbiter: RTL and testbench

- Owns the single external SRAM port.
- Sequences power-on: holds the machine in reset, reads the scandoubler config byte from SRAM at CFG_ADDR, then releases the machine.
- After boot, time-slices the SRAM between the machine (fixed slots 0–1) and a host requester (CtrlModule disk/OSD path, slot 2).
- Runs on the 24 MHz SRAM multiplexer clock. There are 4 slots per 6 MHz CPU cycle.

---
 rtl/sram_arb_pkg.sv | 18 +
 rtl/sram_boot_arbiter.sv | 151 +++++++++++++++
 tb/tb_sram_boot_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM boot sequencer / slot arbiter.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    ST_BOOT_WAIT = 2'd0,
    ST_BOOT_READ = 2'd1,
    ST_RUN       = 2'd2
  } state_t;

  localparam logic [1:0] SLOT_SAM0 = 2'd0;
  localparam logic [1:0] SLOT_SAM1 = 2'd1;
  localparam logic [1:0] SLOT_HOST = 2'd2;
  localparam logic [1:0] SLOT_TURN = 2'd3;

  localparam logic [20:0] DEF_CFG_ADDR = 21'h008FD5;
  localparam logic [20:0] DEF_WP_BASE  = 21'h1C0000;

endpackage

// File: rtl/sram_boot_arbiter.sv
// Boot-time config byte fetch, then 4-slot SRAM time-slicing: machine (0,1), host (2), turnaround (3).
// Optional host write protection at and above WP_BASE: define SRAM_HOST_WP_EN.
module sram_boot_arbiter
  import sram_arb_pkg::*;
#(
  parameter logic [20:0] CFG_ADDR  = DEF_CFG_ADDR,
  parameter int unsigned BOOT_WAIT = 64,
  parameter logic [20:0] WP_BASE   = DEF_WP_BASE
) (
  input  logic        clk24,
  input  logic        reset,
  input  logic [18:0] sam_addr,
  input  logic        sam_we_n,
  input  logic [7:0]  sam_wdata,
  output logic [7:0]  sam_rdata,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [20:0] host_addr,
  input  logic [7:0]  host_wdata,
  output logic        host_ack,
  output logic [7:0]  host_rdata,
  output logic        host_wp_err,
  output logic [20:0] sram_addr,
  output logic [7:0]  sram_dq_o,
  output logic        sram_dq_oe,
  input  logic [7:0]  sram_dq_i,
  output logic        sram_we_n,
  output logic        sram_oe_n,
  output logic [7:0]  cfg_byte,
  output logic        cfg_valid,
  output logic        master_reset_n
);

  localparam logic [7:0] BOOT_LAST = 8'(BOOT_WAIT - 1);

  state_t     state;
  logic [7:0] boot_cnt;
  logic [1:0] slot;
  logic       host_busy;
  logic       host_rd;
  logic       host_blk;
  logic       wp_block;

`ifdef SRAM_HOST_WP_EN
  assign wp_block = host_we & (host_addr >= WP_BASE);
`else
  // Constant zero; the compare only keeps WP_BASE referenced.
  assign wp_block = 1'b0 & (host_addr >= WP_BASE);
`endif

  assign sram_oe_n = ~sram_we_n;

  // Boot sequencer, slot counter and registered SRAM/host outputs.
  always_ff @(posedge clk24 or posedge reset) begin
    if (reset) begin
      state          <= ST_BOOT_WAIT;
      boot_cnt       <= 8'd0;
      slot           <= SLOT_SAM0;
      sram_addr      <= CFG_ADDR;
      sram_we_n      <= 1'b1;
      sram_dq_oe     <= 1'b0;
      sram_dq_o      <= 8'd0;
      host_ack       <= 1'b0;
      host_wp_err    <= 1'b0;
      host_rdata     <= 8'd0;
      sam_rdata      <= 8'd0;
      cfg_byte       <= 8'd0;
      cfg_valid      <= 1'b0;
      master_reset_n <= 1'b0;
      host_busy      <= 1'b0;
      host_rd        <= 1'b0;
      host_blk       <= 1'b0;
    end else begin
      host_ack    <= 1'b0;
      host_wp_err <= 1'b0;
      case (state)
        ST_BOOT_WAIT: begin
          sram_addr  <= CFG_ADDR;
          sram_we_n  <= 1'b1;
          sram_dq_oe <= 1'b0;
          if (boot_cnt == BOOT_LAST) begin
            state <= ST_BOOT_READ;
          end else begin
            boot_cnt <= boot_cnt + 8'd1;
          end
        end
        ST_BOOT_READ: begin
          cfg_byte   <= sram_dq_i;
          cfg_valid  <= 1'b1;
          slot       <= SLOT_SAM0;
          state      <= ST_RUN;
          sram_addr  <= {2'b00, sam_addr};
          sram_we_n  <= 1'b1;
          sram_dq_oe <= 1'b0;
        end
        ST_RUN: begin
          master_reset_n <= 1'b1;
          slot           <= slot + 2'd1;
          // Each arm ends the current slot and sets up the bus for the next one.
          case (slot)
            SLOT_SAM0: begin
              sram_addr  <= {2'b00, sam_addr};
              sram_we_n  <= sam_we_n;
              sram_dq_oe <= ~sam_we_n;
              sram_dq_o  <= sam_wdata;
            end
            SLOT_SAM1: begin
              if (sram_we_n) begin
                sam_rdata <= sram_dq_i;
              end
              if (host_req) begin
                host_busy  <= 1'b1;
                host_rd    <= ~host_we;
                host_blk   <= wp_block;
                sram_addr  <= host_addr;
                sram_dq_o  <= host_wdata;
                sram_we_n  <= ~(host_we & ~wp_block);
                sram_dq_oe <= host_we & ~wp_block;
              end else begin
                host_busy  <= 1'b0;
                sram_we_n  <= 1'b1;
                sram_dq_oe <= 1'b0;
              end
            end
            SLOT_HOST: begin
              sram_we_n   <= 1'b1;
              sram_dq_oe  <= 1'b0;
              host_ack    <= host_busy;
              host_wp_err <= host_busy & host_blk;
              if (host_busy & host_rd) begin
                host_rdata <= sram_dq_i;
              end
              host_busy <= 1'b0;
            end
            SLOT_TURN: begin
              sram_addr  <= {2'b00, sam_addr};
              sram_we_n  <= 1'b1;
              sram_dq_oe <= 1'b0;
            end
            default: begin
              sram_we_n  <= 1'b1;
              sram_dq_oe <= 1'b0;
            end
          endcase
        end
        default: state <= ST_BOOT_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_boot_arbiter.sv
// Randomized bench for sram_boot_arbiter with a cycle-level slot model and a behavioural SRAM.
`timescale 1ns/1ps
module tb_sram_boot_arbiter;

  localparam logic [20:0] CFG = 21'h008FD5;
  localparam int          BW  = 64;
  localparam logic [20:0] WPB = 21'h1C0000;
`ifdef SRAM_HOST_WP_EN
  localparam logic WP_ON = 1'b1;
`else
  localparam logic WP_ON = 1'b0;
`endif

  logic        clk24 = 1'b0;
  logic        reset = 1'b0;
  logic [18:0] sam_addr = 19'd0;
  logic        sam_we_n = 1'b1;
  logic [7:0]  sam_wdata = 8'd0;
  logic [7:0]  sam_rdata;
  logic        host_req = 1'b0;
  logic        host_we = 1'b0;
  logic [20:0] host_addr = 21'd0;
  logic [7:0]  host_wdata = 8'd0;
  logic        host_ack;
  logic [7:0]  host_rdata;
  logic        host_wp_err;
  logic [20:0] sram_addr;
  logic [7:0]  sram_dq_o;
  logic        sram_dq_oe;
  logic [7:0]  sram_dq_i = 8'd0;
  logic        sram_we_n;
  logic        sram_oe_n;
  logic [7:0]  cfg_byte;
  logic        cfg_valid;
  logic        master_reset_n;

  always #5 clk24 = ~clk24;

  sram_boot_arbiter dut (
    .clk24(clk24), .reset(reset),
    .sam_addr(sam_addr), .sam_we_n(sam_we_n), .sam_wdata(sam_wdata), .sam_rdata(sam_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rdata(host_rdata), .host_wp_err(host_wp_err),
    .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe), .sram_dq_i(sram_dq_i),
    .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n),
    .cfg_byte(cfg_byte), .cfg_valid(cfg_valid), .master_reset_n(master_reset_n)
  );

  typedef struct packed {
    logic        we;
    logic [20:0] addr;
    logic [7:0]  data;
  } txn_t;

  logic [7:0] sram_mem [int];   // the physical SRAM, written by the DUT's bus
  logic [7:0] ref_mem  [int];   // what memory must hold according to the model
  txn_t       hq [$];
  int         ack_times [$];
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  logic       rand_sam = 1'b0;
  logic [7:0] last_rdata = 8'd0;
  logic       last_wp = 1'b0;

  // Model state: n counts clock edges since reset release.
  int          n;
  int          e_slot;
  logic        served, srv_we, srv_blk;
  logic [20:0] e_addr;
  logic        e_we_n, e_oe, e_ack, e_wp, e_cfg_valid, e_mrn;
  logic [7:0]  e_dq_o, e_cfg, e_sam_rdata, e_host_rdata;

  function automatic logic [7:0] seed(input logic [20:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] sram_rd(input logic [20:0] a);
    if (sram_mem.exists(int'(a))) return sram_mem[int'(a)];
    return seed(a);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [20:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return seed(a);
  endfunction

  // Asynchronous SRAM: writes while we_n is low, read data follows the address.
  initial begin
    forever begin
      @(negedge clk24);
      if (!sram_we_n) sram_mem[int'(sram_addr)] = sram_dq_o;
      sram_dq_i = sram_rd(sram_addr);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic bound_fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: wait budget expired at cycle %0d", nm, cyc);
  endtask

  task automatic model_reset();
    n = 0; e_slot = -1; served = 1'b0; srv_we = 1'b0; srv_blk = 1'b0;
    e_addr = CFG; e_we_n = 1'b1; e_oe = 1'b0; e_dq_o = 8'd0;
    e_ack = 1'b0; e_wp = 1'b0; e_cfg_valid = 1'b0; e_mrn = 1'b0;
    e_cfg = 8'd0; e_sam_rdata = 8'd0; e_host_rdata = 8'd0;
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_edge();
    if (reset) begin
      model_reset();
      return;
    end
    if (!e_we_n) ref_mem[int'(e_addr)] = e_dq_o;
    if (e_slot == 1 && e_we_n) e_sam_rdata = ref_rd(e_addr);
    if (e_slot == 2 && served && !srv_we) e_host_rdata = ref_rd(e_addr);
    if (n == BW) e_cfg = ref_rd(CFG);
    n++;
    e_ack = 1'b0;
    e_wp = 1'b0;
    if (n >= BW + 1) begin
      e_cfg_valid = 1'b1;
      e_mrn = (n >= BW + 2);
      e_slot = (n - BW - 1) % 4;
      case (e_slot)
        0: begin e_addr = {2'b00, sam_addr}; e_we_n = 1'b1; e_oe = 1'b0; end
        1: begin
          e_addr = {2'b00, sam_addr}; e_we_n = sam_we_n; e_oe = ~sam_we_n; e_dq_o = sam_wdata;
        end
        2: begin
          if (host_req) begin
            served = 1'b1; srv_we = host_we;
            srv_blk = WP_ON && host_we && (host_addr >= WPB);
            e_addr = host_addr; e_dq_o = host_wdata;
            e_oe = host_we && !srv_blk; e_we_n = !e_oe;
          end else begin
            served = 1'b0; e_we_n = 1'b1; e_oe = 1'b0;
          end
        end
        default: begin
          e_we_n = 1'b1; e_oe = 1'b0; e_ack = served; e_wp = served && srv_blk; served = 1'b0;
        end
      endcase
    end else begin
      e_slot = -1;
    end
  endtask

  task automatic compare();
    logic e_oe_n;
    e_oe_n = ~e_we_n;
    chk("sram_addr", sram_addr, e_addr);
    chk("sram_we_n", sram_we_n, e_we_n);
    chk("sram_oe_n", sram_oe_n, e_oe_n);
    chk("sram_dq_oe", sram_dq_oe, e_oe);
    if (e_oe) chk("sram_dq_o", sram_dq_o, e_dq_o);
    chk("host_ack", host_ack, e_ack);
    chk("host_wp_err", host_wp_err, e_wp);
    chk("host_rdata", host_rdata, e_host_rdata);
    chk("sam_rdata", sam_rdata, e_sam_rdata);
    chk("cfg_valid", cfg_valid, e_cfg_valid);
    chk("cfg_byte", cfg_byte, e_cfg);
    chk("master_reset_n", master_reset_n, e_mrn);
  endtask

  task automatic present();
    if (hq.size() > 0) begin
      host_req = 1'b1; host_we = hq[0].we; host_addr = hq[0].addr; host_wdata = hq[0].data;
    end else begin
      host_req = 1'b0;
    end
  endtask

  task automatic push_txn(input logic we, input logic [20:0] a, input logic [7:0] d);
    txn_t t;
    t.we = we; t.addr = a; t.data = d;
    hq.push_back(t);
    present();
  endtask

  task automatic step();
    @(posedge clk24);
    #1;
    model_edge();
    compare();
    if (host_ack) begin
      ack_times.push_back(cyc);
      last_rdata = host_rdata;
      last_wp = host_wp_err;
      if (hq.size() > 0) hq.delete(0);
    end
    present();
    if (rand_sam) begin
      sam_addr = 19'h00100 + 19'($urandom_range(0, 15));
      sam_we_n = 1'($urandom_range(0, 1));
      sam_wdata = 8'($urandom);
    end
    cyc++;
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int b = 0;
    while (hq.size() > 0 && b < budget) begin step(); b++; end
    if (hq.size() > 0) begin bound_fail(nm); hq.delete(); present(); end
  endtask

  task automatic wait_slot3();
    int b = 0;
    while (e_slot != 3 && b < 8) begin step(); b++; end
    if (e_slot != 3) bound_fail("align_slot3");
  endtask

  task automatic boot_phase(input logic [7:0] exp_cfg);
    int kv = -1;
    int km = -1;
    for (int k = 1; k <= BW + 3; k++) begin
      step();
      if (cfg_valid && kv < 0) kv = k;
      if (master_reset_n && km < 0) km = k;
    end
    chk("boot_cfg_valid_cycle", kv, 32'd65);
    chk("boot_mrn_cycle", km, 32'd66);
    chk("boot_cfg_byte", cfg_byte, exp_cfg);
  endtask

  task automatic rand_host();
    logic [20:0] a;
    case ($urandom_range(0, 5))
      0: a = 21'h100000 + 21'($urandom_range(0, 7));
      1: a = 21'h000100 + 21'($urandom_range(0, 15));
      2: a = 21'h1C0000;
      3: a = 21'h1BFFFF;
      4: a = 21'h1C0001;
      default: a = 21'h1FFFFF;
    endcase
    push_txn(1'($urandom_range(0, 1)), a, 8'($urandom));
  endtask

  initial begin
    sram_mem[int'(CFG)] = 8'h02;            ref_mem[int'(CFG)] = 8'h02;
    sram_mem[int'(21'h100000)] = 8'h3C;     ref_mem[int'(21'h100000)] = 8'h3C;
    sram_mem[int'(21'h1C0010)] = 8'h77;     ref_mem[int'(21'h1C0010)] = 8'h77;
    model_reset();
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    boot_phase(8'h02);

    // Directed machine write then read of 0x00100.
    wait_slot3();
    sam_addr = 19'h00100; sam_we_n = 1'b0; sam_wdata = 8'hA5;
    repeat (4) step();
    sam_we_n = 1'b1;
    repeat (4) step();
    chk("sam_read_after_write", sam_rdata, 32'h0000_00A5);
    chk("sram_mem_0x100", sram_rd(21'h000100), 32'h0000_00A5);

    // Host read of preloaded 0x100000.
    push_txn(1'b0, 21'h100000, 8'h00);
    wait_idle("host_read", 20);
    chk("host_read_data", last_rdata, 32'h0000_003C);

    // Three back-to-back host writes with req held high.
    ack_times.delete();
    push_txn(1'b1, 21'h100001, 8'h11);
    push_txn(1'b1, 21'h100002, 8'h22);
    push_txn(1'b1, 21'h100003, 8'h33);
    wait_idle("b2b", 40);
    chk("b2b_ack_count", ack_times.size(), 32'd3);
    if (ack_times.size() == 3) begin
      chk("b2b_gap1", ack_times[1] - ack_times[0], 32'd4);
      chk("b2b_gap2", ack_times[2] - ack_times[1], 32'd4);
    end
    chk("b2b_mem", sram_rd(21'h100002), 32'h0000_0022);

    // Randomized machine traffic with interleaved host accesses.
    rand_sam = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if (hq.size() < 2 && $urandom_range(0, 3) == 0) rand_host();
      step();
    end
    wait_idle("random_drain", 40);
    rand_sam = 1'b0;
    sam_we_n = 1'b1;
    repeat (4) step();

    // Host write of 0xFF to 0x1C0010, then read it back.
    push_txn(1'b1, 21'h1C0010, 8'hFF);
    wait_idle("wp_write", 20);
    chk("wp_err_pulse", last_wp, WP_ON);
    chk("wp_mem", sram_rd(21'h1C0010), WP_ON ? 32'h0000_0077 : 32'h0000_00FF);
    push_txn(1'b0, 21'h1C0010, 8'h00);
    wait_idle("wp_readback", 20);
    chk("wp_readback", last_rdata, WP_ON ? 32'h0000_0077 : 32'h0000_00FF);
    chk("wp_read_no_err", last_wp, 32'd0);

    // New config byte, then reset in the middle of a host write.
    push_txn(1'b1, CFG, 8'h5E);
    wait_idle("cfg_write", 20);
    push_txn(1'b1, 21'h100005, 8'h99);
    begin
      int b = 0;
      while (!(e_slot == 2 && !e_we_n) && b < 20) begin step(); b++; end
      if (!(e_slot == 2 && !e_we_n)) bound_fail("reach_host_write");
    end
    #2;
    reset = 1'b1;
    #1;
    chk("rst_we_n", sram_we_n, 32'd1);
    chk("rst_ack", host_ack, 32'd0);
    chk("rst_addr", sram_addr, 32'(CFG));
    model_reset();
    compare();
    repeat (2) step();
    reset = 1'b0;
    boot_phase(8'h5E);
    wait_idle("dropped_write_retry", 20);
    chk("retry_mem", sram_rd(21'h100005), 32'h0000_0099);
    repeat (8) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
